// File: rtl/axi2apb_reg_pkg.sv
// Shared definitions for the APB register decoder: slot map, FSM encoding
// and wait-counter width.
package axi2apb_reg_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int WS_W      = 3;
  localparam int ADDR_W    = 12;

  localparam logic [ADDR_W-1:0] SLOT0_OFF = 12'h000;
  localparam logic [ADDR_W-1:0] SLOT1_OFF = 12'h004;
  localparam logic [ADDR_W-1:0] SLOT2_OFF = 12'h008;
  localparam logic [ADDR_W-1:0] SLOT3_OFF = 12'h010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [1:0] idx;
  } slot_dec_t;

  // Exact match on the full offset; anything else is unmapped.
  function automatic slot_dec_t decode_slot(input logic [ADDR_W-1:0] addr);
    slot_dec_t r;
    r = '0;
    case (addr)
      SLOT0_OFF: r = '{hit: 1'b1, idx: 2'd0};
      SLOT1_OFF: r = '{hit: 1'b1, idx: 2'd1};
      SLOT2_OFF: r = '{hit: 1'b1, idx: 2'd2};
      SLOT3_OFF: r = '{hit: 1'b1, idx: 2'd3};
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Down-counter that times the wait states of an APB access phase.
module apb_wait_cnt
  import axi2apb_reg_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [WS_W-1:0] load_val,
  input  logic            dec,
  output logic            zero
);

  logic [WS_W-1:0] cnt_q;
  logic [WS_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/apb_reg_decoder.sv
// APB4 slave that maps four 32-bit register slots, inserts a fixed number of
// wait states and flags decode/strobe errors through pslverr.
module apb_reg_decoder
  import axi2apb_reg_pkg::*;
#(
  parameter int unsigned WAIT_STATES  = 1,
  parameter bit          ERR_ON_PSTRB = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         psel,
  input  logic         penable,
  input  logic         pwrite,
  input  logic [11:0]  paddr,
  input  logic [31:0]  pwdata,
  input  logic [3:0]   pstrb,
  output logic [31:0]  prdata,
  output logic         pready,
  output logic         pslverr,
  output logic [3:0]   reg_write,
  output logic [31:0]  reg_wdata,
  input  logic [127:0] reg_rdata,
  output logic [1:0]   dbg_state
);

  // Handshake: a transfer starts with a setup cycle (psel=1, penable=0) seen
  // in IDLE; pready is high for exactly one cycle and pslverr/prdata/reg_write
  // are only meaningful in that cycle, being 0 in every other cycle.
  localparam logic [WS_W-1:0] WS_LOAD =
    (WAIT_STATES > 0) ? WS_W'(WAIT_STATES - 1) : '0;

  state_e      state_q, state_d;
  logic [11:0] addr_q, addr_d;
  logic        write_q, write_d;
  logic [3:0]  strb_q, strb_d;
  logic [31:0] reg_wdata_q, reg_wdata_d;
  logic        pready_q, pready_d;
  logic        pslverr_q, pslverr_d;
  logic [31:0] prdata_q, prdata_d;
  logic [3:0]  reg_write_q, reg_write_d;

  logic        cnt_load, cnt_dec, cnt_zero;
  logic        go_done;
  slot_dec_t   done_slot;
  logic        done_err;

  apb_wait_cnt u_wait_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WS_LOAD),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    write_d     = write_q;
    strb_d      = strb_q;
    reg_wdata_d = reg_wdata_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    reg_write_d = '0;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;
    go_done     = 1'b0;
    done_slot   = '0;
    done_err    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          addr_d      = paddr;
          write_d     = pwrite;
          strb_d      = pstrb;
          reg_wdata_d = pwdata;
          if (WAIT_STATES > 0) begin
            state_d  = ST_WAIT;
            cnt_load = 1'b1;
          end else begin
            go_done = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          state_d = ST_IDLE;
        end else if (cnt_zero) begin
          go_done = 1'b1;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Decode from the _d copies so the zero-wait path sees the setup values.
    if (go_done) begin
      done_slot = decode_slot(addr_d);
      done_err  = !done_slot.hit || (addr_d[1:0] != 2'b00) ||
                  (ERR_ON_PSTRB && write_d && (strb_d != 4'hF));
      state_d   = ST_DONE;
      pready_d  = 1'b1;
      pslverr_d = done_err;
      if (!done_err) begin
        if (write_d) begin
          reg_write_d = 4'b0001 << done_slot.idx;
        end else begin
          prdata_d = reg_rdata[{done_slot.idx, 5'b00000} +: 32];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      write_q     <= 1'b0;
      strb_q      <= '0;
      reg_wdata_q <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      reg_write_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      strb_q      <= strb_d;
      reg_wdata_q <= reg_wdata_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      reg_write_q <= reg_write_d;
    end
  end

  assign prdata    = prdata_q;
  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign reg_write = reg_write_q;
  assign reg_wdata = reg_wdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_apb_reg_decoder.sv
// Bench for apb_reg_decoder: three instances (WAIT_STATES/ERR_ON_PSTRB =
// 1/1, 0/0, 3/1) driven by directed APB transfers against a queued model.
module tb_apb_reg_decoder;

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  wr;
    logic [31:0] wdata;
    logic [4:0]  cycles;
  } exp_t;

  logic clk;
  logic rst;
  logic [2:0]         psel, penable, pwrite;
  logic [2:0][11:0]   paddr;
  logic [2:0][31:0]   pwdata;
  logic [2:0][3:0]    pstrb;
  logic [2:0][31:0]   prdata;
  logic [2:0]         pready, pslverr;
  logic [2:0][3:0]    reg_write;
  logic [2:0][31:0]   reg_wdata;
  logic [2:0][127:0]  reg_rdata;
  logic [2:0][1:0]    dbg_state;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    apb_reg_decoder #(
      .WAIT_STATES  ((g == 0) ? 1 : (g == 1) ? 0 : 3),
      .ERR_ON_PSTRB ((g == 1) ? 1'b0 : 1'b1)
    ) dut (
      .clk       (clk),
      .rst       (rst),
      .psel      (psel[g]),
      .penable   (penable[g]),
      .pwrite    (pwrite[g]),
      .paddr     (paddr[g]),
      .pwdata    (pwdata[g]),
      .pstrb     (pstrb[g]),
      .prdata    (prdata[g]),
      .pready    (pready[g]),
      .pslverr   (pslverr[g]),
      .reg_write (reg_write[g]),
      .reg_wdata (reg_wdata[g]),
      .reg_rdata (reg_rdata[g]),
      .dbg_state (dbg_state[g])
    );
  end

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic int ws_of(input int d);
    case (d)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic bit eop_of(input int d);
    return d != 1;
  endfunction

  // Reference model of one transfer.
  function automatic exp_t model(input int d, input logic wr, input logic [11:0] a,
                                 input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    bit   hit;
    int   idx;
    hit = 1'b1;
    idx = 0;
    case (a)
      12'h000: idx = 0;
      12'h004: idx = 1;
      12'h008: idx = 2;
      12'h010: idx = 3;
      default: hit = 1'b0;
    endcase
    e.err    = !hit || (a[1:0] != 2'b00) || (eop_of(d) && wr && st != 4'hF);
    e.rdata  = (!wr && !e.err) ? reg_rdata[d][idx*32 +: 32] : 32'h0;
    e.wr     = (wr && !e.err) ? (4'b0001 << idx) : 4'b0000;
    e.wdata  = wd;
    e.cycles = 5'(ws_of(d) + 1);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: setup is driven immediately so consecutive calls are back-to-back.
  task automatic xfer(input int d, input logic wr, input logic [11:0] a,
                      input logic [31:0] wd, input logic [3:0] st);
    exp_t e;
    int   n;
    int   pulses;
    bit   done;
    exp_q.push_back(model(d, wr, a, wd, st));
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr;
    paddr[d] = a; pwdata[d] = wd; pstrb[d] = st;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0; pulses = 0; done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
      if (reg_write[d] != 4'b0) pulses++;
      if (pready[d]) begin
        e = exp_q.pop_front();
        done = 1'b1;
        chk($sformatf("access_cycles d%0d a%0h", d, a), 128'(n), 128'(e.cycles));
        chk($sformatf("pslverr d%0d a%0h", d, a), 128'(pslverr[d]), 128'(e.err));
        chk($sformatf("prdata d%0d a%0h", d, a), 128'(prdata[d]), 128'(e.rdata));
        chk($sformatf("reg_write d%0d a%0h", d, a), 128'(reg_write[d]), 128'(e.wr));
        if (wr) chk($sformatf("reg_wdata d%0d a%0h", d, a), 128'(reg_wdata[d]), 128'(e.wdata));
        chk($sformatf("pulses d%0d a%0h", d, a), 128'(pulses), 128'(e.wr != 4'b0));
      end else begin
        chk($sformatf("quiet_outs d%0d a%0h", d, a),
            {prdata[d], pslverr[d], reg_write[d]}, 128'h0);
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      chk($sformatf("pready_timeout d%0d a%0h", d, a), 128'(done), 128'h1);
      void'(exp_q.pop_front());
    end
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int sel;
    logic [11:0] addrs[7];
    addrs = '{12'h000, 12'h004, 12'h008, 12'h010, 12'h00C, 12'h006, 12'h014};
    rst = 1'b1;
    psel = '0; penable = '0; pwrite = '0; paddr = '0; pwdata = '0; pstrb = '0;
    reg_rdata[0] = {32'h0000_0001, 32'hA5A5_0008, 32'h1234_0004, 32'hDEAD_0000};
    reg_rdata[1] = {32'h7777_0010, 32'h5A5A_0008, 32'h3333_0004, 32'hBEEF_0000};
    reg_rdata[2] = {$urandom, $urandom, $urandom, $urandom};

    // Reset state
    idle(2);
    for (int d = 0; d < 3; d++)
      chk($sformatf("reset_outs d%0d", d),
          {prdata[d], pready[d], pslverr[d], reg_write[d], reg_wdata[d], dbg_state[d]}, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Slot3 write/read, one wait state
    xfer(0, 1'b1, 12'h010, 32'h0000_0001, 4'hF);
    idle(1);
    xfer(0, 1'b0, 12'h010, 32'h0, 4'hF);
    idle(1);
    // Unmapped write, misaligned read
    xfer(0, 1'b1, 12'h00C, $urandom, 4'hF);
    xfer(0, 1'b0, 12'h006, 32'h0, 4'hF);
    idle(1);
    // Partial strobe: error with strobe checking, accepted without
    xfer(0, 1'b1, 12'h004, 32'h1111_2222, 4'h3);
    xfer(1, 1'b1, 12'h004, 32'h3333_4444, 4'h3);
    idle(2);
    // Zero wait states, back-to-back write then read
    xfer(1, 1'b1, 12'h000, 32'hCAFE_0000, 4'hF);
    xfer(1, 1'b0, 12'h008, 32'h0, 4'hF);
    idle(1);
    // Three wait states
    xfer(2, 1'b0, 12'h008, 32'h0, 4'hF);
    xfer(2, 1'b1, 12'h004, $urandom, 4'hF);
    xfer(2, 1'b0, 12'h000, 32'h0, 4'hF);
    xfer(2, 1'b1, 12'h010, $urandom, 4'hE);
    idle(1);

    // Random mix on each instance
    for (int i = 0; i < 12; i++) begin
      sel = $urandom_range(0, 6);
      xfer(i % 3, 1'($urandom_range(0, 1)), addrs[sel], $urandom,
           ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF);
      idle($urandom_range(0, 2));
    end

    // psel dropped during the wait state aborts the transfer
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 12'h000; pwdata[0] = 32'h5555_AAAA; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    @(negedge clk);
    chk("abort_in_wait", 128'(dbg_state[0]), 128'(1));
    psel[0] = 1'b0; penable[0] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk($sformatf("abort_quiet %0d", k),
          {pready[0], reg_write[0], pslverr[0], dbg_state[0]}, 128'h0);
    end
    @(posedge clk); #1;

    // Reset in the wait state of a write to slot3
    psel[0] = 1'b1; penable[0] = 1'b0; pwrite[0] = 1'b1;
    paddr[0] = 12'h010; pwdata[0] = 32'hCAFE_F00D; pstrb[0] = 4'hF;
    @(posedge clk); #1;
    penable[0] = 1'b1;
    #2;
    chk("pre_reset_wdata", 128'(reg_wdata[0]), 128'h0000_0000_0000_0000_0000_0000_CAFE_F00D);
    rst = 1'b1;
    #1;
    chk("async_reset_outs",
        {prdata[0], pready[0], pslverr[0], reg_write[0], reg_wdata[0], dbg_state[0]}, 128'h0);
    psel[0] = 1'b0; penable[0] = 1'b0;
    @(negedge clk);
    chk("reset_no_pulse", {reg_write[0], pready[0]}, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    xfer(0, 1'b1, 12'h010, 32'h0000_1234, 4'hF);
    xfer(0, 1'b0, 12'h008, 32'h0, 4'hF);
    idle(2);

    chk("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/apb_reg_decoder.md
APB_REG_DECODER -- requirements
Module: apb_reg_decoder

Interface
REQ-001 Parameter WAIT_STATES, default 1: number of pready-low cycles inserted in each access phase; legal values 0..7.
REQ-002 Parameter ERR_ON_PSTRB, default 1: when 1, a write with pstrb != 4'hF is an error.
REQ-003 Port clk, input, 1: single clock; all logic is on posedge clk.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port psel, input, 1: APB4 select.
REQ-006 Port penable, input, 1: APB4 enable.
REQ-007 Port pwrite, input, 1: APB4 direction; 1 means write.
REQ-008 Port paddr, input, 12: byte offset within the slave window.
REQ-009 Port pwdata, input, 32: write data.
REQ-010 Port pstrb, input, 4: write byte strobes.
REQ-011 Port prdata, output, 32: read data, registered.
REQ-012 Port pready, output, 1: transfer complete, registered.
REQ-013 Port pslverr, output, 1: transfer error, registered, qualified by pready.
REQ-014 Port reg_write, output, 4: one-hot write pulse; bit i selects register slot i.
REQ-015 Port reg_wdata, output, 32: write data to the register slots, registered.
REQ-016 Port reg_rdata, input, 128: read data from the slots; slot i occupies bits [32i+31:32i].

Function
REQ-017 Slot offsets SHALL be fixed: slot0=0x000, slot1=0x004, slot2=0x008, slot3=0x010 (slave config register).
REQ-018 The FSM SHALL have three states: IDLE, WAIT, DONE.
REQ-019 In IDLE, psel=1 with penable=0 (setup phase) SHALL latch paddr, pwrite, pwdata and pstrb, then go to WAIT if WAIT_STATES>0, otherwise to DONE.
REQ-020 On entry to WAIT the counter SHALL load WAIT_STATES-1 and decrement each cycle; the FSM SHALL go to DONE when the counter is 0.
REQ-021 pready SHALL be 1 only in DONE, for exactly one cycle; DONE SHALL always return to IDLE.
REQ-022 Access-phase length SHALL be WAIT_STATES+1 cycles of penable=1, with pready=1 in the last of them.
REQ-023 An error SHALL be flagged for: an unmapped offset, paddr[1:0]!=0, or (ERR_ON_PSTRB=1 and a write with pstrb!=4'hF).
REQ-024 pslverr SHALL be 1 in DONE only when an error is flagged; it SHALL be 0 at all other times.
REQ-025 On an error-free write, reg_write[i] SHALL pulse for exactly the DONE cycle, with reg_wdata holding the latched pwdata; the slot captures it at the next edge.
REQ-026 On an error write, reg_write SHALL stay 0.
REQ-027 On a read, prdata SHALL be the selected reg_rdata slice sampled on entry to DONE.
REQ-028 On an error read, prdata SHALL be 0.
REQ-029 prdata SHALL be 0 whenever pready=0.
REQ-030 If psel drops while in WAIT (protocol violation), the FSM SHALL return to IDLE with no write pulse and no pready.
REQ-031 A setup phase arriving in the cycle directly after DONE SHALL be accepted (back-to-back transfers, no idle cycle required).
REQ-032 At most one reg_write bit SHALL be set in any cycle.

Reset
REQ-033 While rst=1: state=IDLE, counter=0, pready=0, pslverr=0, prdata=0, reg_write=0, reg_wdata=0.
REQ-034 Reset asserted mid-transfer SHALL abort it immediately, with no write pulse; the first transfer after deassertion SHALL start from IDLE.

Structure
REQ-035 The shared package axi2apb_reg_pkg SHALL hold the slot offsets, the slot count (4), the FSM state encoding, and the WAIT_STATES width (3).
REQ-036 The wait counter SHALL be one sub-module, apb_wait_cnt, with inputs load, load_val and dec, and output zero.

Verification
REQ-037 Write 0x0000_0001 to 0x010 with WAIT_STATES=1 -> pready high in the 2nd access cycle; reg_write=4'b1000 for 1 cycle; reg_wdata=0x0000_0001; pslverr=0.
REQ-038 Read 0x010 with reg_rdata[127:96]=0x0000_0001 -> prdata=0x0000_0001 with pready; pslverr=0.
REQ-039 Write to 0x00C, then read 0x006 -> both transfers have pslverr=1; reg_write stays 0; the read returns prdata=0.
REQ-040 Write to 0x004 with pstrb=4'h3 -> pslverr=1, no pulse; repeat with ERR_ON_PSTRB=0 -> reg_write=4'b0010, pslverr=0.
REQ-041 Back-to-back write 0x000 then read 0x008 with WAIT_STATES=0 -> pready high in every access cycle; exactly one write pulse, on slot0.
REQ-042 Assert rst in WAIT during a write to 0x010 -> all outputs 0 asynchronously; no reg_write pulse; the next transfer completes normally.
